// File: rtl/tdm_demux_if.sv
// Serial-side and frame-side signals of the TDM demultiplexer.
// master: drives the serial stream and observes frames; slave: the demux itself.
interface tdm_demux_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8
);
    logic                       din;
    logic                       din_valid;
    logic                       sync;
    logic [CHANNELS*WIDTH-1:0]  dout;
    logic                       frame_valid;
    logic                       sync_err;
    logic                       parity_err;

    modport master (
        output din, din_valid, sync,
        input  dout, frame_valid, sync_err, parity_err
    );

    modport slave (
        input  din, din_valid, sync,
        output dout, frame_valid, sync_err, parity_err
    );
endinterface

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: collects CHANNELS slots of WIDTH bits (MSB first)
// after a sync strobe and publishes the whole frame on dout in one step.
// Optional feature macro: TDM_DEMUX_PARITY_EN adds a trailing even-parity
// bit per slot; a frame with any bad slot is dropped and flagged on parity_err.
module tdm_demux #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux_if.slave   bus
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned L  = WIDTH + PAR;
    localparam int unsigned BW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned SW = $clog2(CHANNELS);
    localparam int unsigned DW = CHANNELS * WIDTH;

    typedef enum logic {StHunt, StRecv} state_t;

    state_t          r_state;
    logic [BW-1:0]   r_bit_cnt;
    logic [SW-1:0]   r_slot_cnt;
    logic [L-1:0]    r_shift;
    logic [DW-1:0]   r_stage;
    logic [DW-1:0]   r_dout;
    logic            r_bad;
    logic            r_frame_valid;
    logic            r_sync_err;
    logic            r_parity_err;

    state_t          w_state_nxt;
    logic [BW-1:0]   w_bit_cnt_nxt;
    logic [SW-1:0]   w_slot_cnt_nxt;
    logic [L-1:0]    w_shift_nxt;
    logic [DW-1:0]   w_stage_nxt;
    logic [DW-1:0]   w_dout_nxt;
    logic            w_bad_nxt;
    logic            w_frame_valid_nxt;
    logic            w_sync_err_nxt;
    logic            w_parity_err_nxt;

    logic            w_take;
    logic            w_fresh;
    logic [BW-1:0]   w_bit_pos;
    logic [SW-1:0]   w_slot_pos;
    logic [L-1:0]    w_shift;
    logic [WIDTH-1:0] w_data;
    logic            w_slot_bad;
    logic            w_slot_end;
    logic            w_last;
    logic            w_bad;
    logic [DW-1:0]   w_frame;

    // Decode the accepted bit's frame position and the slot/frame it completes.
    always_comb begin
        // Any valid sync restarts the frame at bit 0, whether hunting or mid-frame.
        w_fresh    = bus.din_valid & bus.sync;
        w_take     = bus.din_valid & (bus.sync | (r_state == StRecv));
        w_bit_pos  = w_fresh ? '0 : r_bit_cnt;
        w_slot_pos = w_fresh ? '0 : r_slot_cnt;
        w_shift    = ((w_fresh ? '0 : r_shift) << 1) | L'(bus.din);
`ifdef TDM_DEMUX_PARITY_EN
        w_data     = w_shift[L-1:1];
        w_slot_bad = ^w_shift;
`else
        w_data     = w_shift[WIDTH-1:0];
        w_slot_bad = 1'b0;
`endif
        w_slot_end = (w_bit_pos == BW'(L - 1));
        w_last     = w_slot_end && (w_slot_pos == SW'(CHANNELS - 1));
        w_bad      = (w_fresh ? 1'b0 : r_bad) | (w_slot_end & w_slot_bad);
        w_frame    = r_stage;
        w_frame[w_slot_pos*WIDTH +: WIDTH] = w_data;
    end

    // Next-state: counters/shift advance only on accepted bits; pulses default low.
    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_slot_cnt_nxt    = r_slot_cnt;
        w_shift_nxt       = r_shift;
        w_stage_nxt       = r_stage;
        w_dout_nxt        = r_dout;
        w_bad_nxt         = r_bad;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;
        w_parity_err_nxt  = 1'b0;
        if (w_take) begin
            w_state_nxt    = StRecv;
            w_shift_nxt    = w_shift;
            w_bad_nxt      = w_bad;
            w_sync_err_nxt = w_fresh && (r_state == StRecv);
            if (w_slot_end) begin
                w_bit_cnt_nxt = '0;
                w_stage_nxt   = w_frame;
                if (w_last) begin
                    w_slot_cnt_nxt = '0;
                    w_state_nxt    = StHunt;
                    if (w_bad) begin
                        w_parity_err_nxt = 1'b1;
                    end else begin
                        w_dout_nxt        = w_frame;
                        w_frame_valid_nxt = 1'b1;
                    end
                end else begin
                    w_slot_cnt_nxt = w_slot_pos + 1'b1;
                end
            end else begin
                w_slot_cnt_nxt = w_slot_pos;
                w_bit_cnt_nxt  = w_bit_pos + 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StHunt;
            r_bit_cnt     <= '0;
            r_slot_cnt    <= '0;
            r_shift       <= '0;
            r_stage       <= '0;
            r_dout        <= '0;
            r_bad         <= 1'b0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_parity_err  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_slot_cnt    <= w_slot_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_stage       <= w_stage_nxt;
            r_dout        <= w_dout_nxt;
            r_bad         <= w_bad_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
            r_parity_err  <= w_parity_err_nxt;
        end
    end

    assign bus.dout        = r_dout;
    assign bus.frame_valid = r_frame_valid;
    assign bus.sync_err    = r_sync_err;
    assign bus.parity_err  = r_parity_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized self-checking bench for tdm_demux against a bit-queue frame model.
module tb_tdm_demux;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned WIDTH    = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned L  = WIDTH + PAR;
    localparam int unsigned FL = CHANNELS * L;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

    tdm_demux #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: accepted bits of the current frame, plus expected outputs.
    bit                        m_bits[$];
    bit                        m_in = 1'b0;
    logic [CHANNELS*WIDTH-1:0] m_dout = '0;
    bit                        e_fv, e_se, e_pe;
    int                        c_fv, c_se, c_pe;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit d, input bit v, input bit s);
        logic [CHANNELS*WIDTH-1:0] frame;
        bit bad;
        int ones;
        e_fv = 0; e_se = 0; e_pe = 0;
        if (!v) return;
        if (s) begin
            if (m_in) e_se = 1;
            m_bits.delete();
            m_bits.push_back(d);
            m_in = 1;
        end else if (m_in) begin
            m_bits.push_back(d);
        end
        if (m_in && m_bits.size() == FL) begin
            frame = '0;
            bad = 0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                ones = 0;
                for (int k = 0; k < L; k++) begin
                    if (k < WIDTH) frame[ch*WIDTH + WIDTH - 1 - k] = m_bits[ch*L + k];
                    ones += int'(m_bits[ch*L + k]);
                end
                if (PAR == 1 && (ones % 2) == 1) bad = 1;
            end
            if (bad) e_pe = 1;
            else begin
                m_dout = frame;
                e_fv = 1;
            end
            m_in = 0;
            m_bits.delete();
        end
    endtask

    task automatic compare_outputs();
        check("dout", 64'(bus.dout), 64'(m_dout));
        check("frame_valid", 64'(bus.frame_valid), 64'(e_fv));
        check("sync_err", 64'(bus.sync_err), 64'(e_se));
        check("parity_err", 64'(bus.parity_err), 64'(e_pe));
        c_fv += int'(bus.frame_valid === 1'b1);
        c_se += int'(bus.sync_err === 1'b1);
        c_pe += int'(bus.parity_err === 1'b1);
    endtask

    task automatic cyc(input bit d, input bit v, input bit s);
        @(negedge clk);
        bus.din = d; bus.din_valid = v; bus.sync = s;
        @(posedge clk);
        model_step(d, v, s);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.din = 1'($urandom_range(1)); bus.din_valid = 1'($urandom_range(1));
        bus.sync = 1'($urandom_range(1));
        @(posedge clk);
        m_bits.delete(); m_in = 0; m_dout = '0; e_fv = 0; e_se = 0; e_pe = 0;
        #1;
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        bus.din_valid = 1'b0;
    endtask

    function automatic bit slot_bit(input logic [CHANNELS*WIDTH-1:0] w, input int ch,
                                    input int k, input int bad_slot);
        if (k < WIDTH) return w[ch*WIDTH + WIDTH - 1 - k];
        return (^w[ch*WIDTH +: WIDTH]) ^ (ch == bad_slot);
    endfunction

    // Sends the first nbits of frame w (sync on bit 0), with random stalls.
    task automatic send_bits(input logic [CHANNELS*WIDTH-1:0] w, input int nbits,
                             input int stall_pct, input int bad_slot);
        int n = 0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int k = 0; k < L; k++) begin
                if (n < nbits) begin
                    while ($urandom_range(99) < stall_pct)
                        cyc(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
                    cyc(slot_bit(w, ch, k, bad_slot), 1'b1, n == 0);
                end
                n++;
            end
        end
    endtask

    task automatic clr_counts();
        c_fv = 0; c_se = 0; c_pe = 0;
    endtask

    initial begin
        logic [CHANNELS*WIDTH-1:0] w;
        int bs;
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0;
        clr_counts();
        repeat (2) @(posedge clk);

        // Reset state, then a plain frame.
        do_reset();
        check("reset_dout", 64'(bus.dout), 64'h0);
        clr_counts();
        send_bits(32'h00FF3CA5, FL, 0, -1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t1_dout", 64'(bus.dout), 64'h00FF3CA5);
        check("t1_pulses", 64'(c_fv), 64'd1);

        // Same frame with stalls.
        do_reset();
        clr_counts();
        send_bits(32'h00FF3CA5, FL, 33, -1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t2_dout", 64'(bus.dout), 64'h00FF3CA5);
        check("t2_pulses", 64'(c_fv), 64'd1);

        // Partial frame aborted by a new sync.
        clr_counts();
        send_bits(32'hDEADBEEF, 12, 0, -1);
        check("t3_hold", 64'(bus.dout), 64'h00FF3CA5);
        send_bits(32'h44332211, FL, 0, -1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t3_dout", 64'(bus.dout), 64'h44332211);
        check("t3_serr", 64'(c_se), 64'd1);

        // Bits without sync while hunting, then reset mid-frame.
        clr_counts();
        repeat (20) cyc(1'($urandom_range(1)), 1'b1, 1'b0);
        check("t4_nopulse", 64'(c_fv + c_se + c_pe), 64'd0);
        check("t4_hold", 64'(bus.dout), 64'h44332211);
        send_bits(32'h12345678, 17, 0, -1);
        do_reset();
        check("t4_rst_dout", 64'(bus.dout), 64'h0);
        repeat (10) cyc(1'($urandom_range(1)), 1'b1, 1'b0);
        send_bits(32'hA1B2C3D4, FL, 0, -1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t4_after", 64'(bus.dout), 64'hA1B2C3D4);

`ifdef TDM_DEMUX_PARITY_EN
        // Bad parity on slot 2 drops the frame.
        clr_counts();
        send_bits(32'h00FF3CA5, FL, 0, 2);
        cyc(1'b0, 1'b0, 1'b0);
        check("t5_perr", 64'(c_pe), 64'd1);
        check("t5_nofv", 64'(c_fv), 64'd0);
        check("t5_hold", 64'(bus.dout), 64'hA1B2C3D4);
`endif

        // Back-to-back frames.
        clr_counts();
        send_bits(32'h0BADF00D, FL, 0, -1);
        send_bits(32'hCAFEBABE, FL, 0, -1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t6_pulses", 64'(c_fv), 64'd2);
        check("t6_serr", 64'(c_se), 64'd0);
        check("t6_dout", 64'(bus.dout), 64'hCAFEBABE);

        // Random mix: frames, aborted frames, junk, stalls, bad parity, resets.
        for (int it = 0; it < 60; it++) begin
            w  = CHANNELS*WIDTH'($urandom());
            bs = (PAR == 1 && $urandom_range(3) == 0) ? int'($urandom_range(CHANNELS - 1)) : -1;
            case ($urandom_range(9))
                0: send_bits(w, int'($urandom_range(FL - 1, 1)), 20, bs);
                1: repeat ($urandom_range(8)) cyc(1'($urandom_range(1)), 1'b1, 1'b0);
                2: if ($urandom_range(3) == 0) do_reset();
                default: send_bits(w, FL, int'($urandom_range(40)), bs);
            endcase
        end
        cyc(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
